// File: rtl/seq0011_tx_pkg.sv
// Shared definitions for the 0011 serial pattern transmitter: FSM encoding and defaults.
package seq0011_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] DefPattern = 4'b0011;
  localparam logic       DefIdleBit = 1'b1;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register; msb is the next bit to leave.
module seq_shift_reg #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [Width-1:0] load_val,
  output logic             msb
);

  logic [Width-1:0] q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[Width-2:0], 1'b0};
    end
  end

  assign msb = q[Width-1];

endmodule

// File: rtl/seq0011_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first reps times with optional idle gaps.
module seq0011_tx
  import seq0011_tx_pkg::*;
#(
  parameter int unsigned      PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(DefPattern),
  parameter int unsigned      CNT_W    = 8,
  parameter int unsigned      GAP_W    = 4,
  parameter logic             IDLE_BIT = DefIdleBit
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             w_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  // First bit goes straight to w_out; the register holds the remaining bits.
  localparam logic [PAT_W-1:0] TAIL     = {PATTERN[PAT_W-2:0], 1'b0};

  state_e           state;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] bit_idx;

  logic sr_msb, sr_load, sr_shift;
  logic accept, last_bit, more_reps, gap_end, halt;

  always_comb begin
    accept    = ((state == StIdle) || (state == StDone)) && start && (reps != '0);
    last_bit  = (state == StShift) && (bit_idx == LAST_IDX);
    more_reps = rep_cnt > CNT_W'(1);
    gap_end   = (state == StGap) && (gap_cnt == GAP_W'(1));
    halt      = abort && ((state == StShift) || (state == StGap));
    sr_load   = accept || (last_bit && more_reps && (gap_len == '0)) || gap_end;
    sr_shift  = (state == StShift) && !last_bit;
  end

  seq_shift_reg #(
    .Width(PAT_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load),
    .shift   (sr_shift),
    .load_val(TAIL),
    .msb     (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= StIdle;
      rep_cnt <= '0;
      gap_len <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
      w_out   <= IDLE_BIT;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (halt) begin
      state <= StIdle;
      w_out <= IDLE_BIT;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          state <= StIdle;
          w_out <= IDLE_BIT;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (accept) begin
            state   <= StShift;
            rep_cnt <= reps;
            gap_len <= gap;
            bit_idx <= '0;
            w_out   <= PATTERN[PAT_W-1];
            valid   <= 1'b1;
            busy    <= 1'b1;
          end else if (start) begin
            // Zero repetitions: completes immediately without ever going busy.
            state <= StDone;
            done  <= 1'b1;
          end
        end
        StShift: begin
          if (!last_bit) begin
            bit_idx <= bit_idx + 1'b1;
            w_out   <= sr_msb;
          end else if (!more_reps) begin
            state   <= StDone;
            rep_cnt <= '0;
            w_out   <= IDLE_BIT;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt - 1'b1;
            bit_idx <= '0;
            if (gap_len == '0) begin
              w_out <= PATTERN[PAT_W-1];
            end else begin
              state   <= StGap;
              gap_cnt <= gap_len;
              w_out   <= IDLE_BIT;
              valid   <= 1'b0;
            end
          end
        end
        StGap: begin
          if (gap_end) begin
            state <= StShift;
            w_out <= PATTERN[PAT_W-1];
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq0011_tx.sv
// Self-checking bench for seq0011_tx: vector table, directed corner cases, random vs. a queue model.
module tb_seq0011_tx;

  localparam int unsigned PAT_W = 4;
  localparam logic [3:0]  PAT   = 4'b0011;
  localparam logic [3:0]  O_IDLE = 4'b1000;  // {w_out, valid, busy, done}
  localparam logic [3:0]  O_GAP  = 4'b1010;
  localparam logic [3:0]  O_DONE = 4'b1001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] reps = '0;
  logic [3:0] gap = '0;
  logic       w_out, valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  seq0011_tx #(
    .PAT_W   (4),
    .PATTERN (4'b0011),
    .CNT_W   (8),
    .GAP_W   (4),
    .IDLE_BIT(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .reps (reps),
    .gap  (gap),
    .abort(abort),
    .w_out(w_out),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  // Model: a queue of expected output words for the cycles still to come.
  logic [3:0] exp_q[$];
  logic [3:0] m_cur = O_IDLE;

  // Capture of the observed line for the directed checks.
  string      wave;
  int         busy_n, done_n, det_n, vcnt;
  logic [3:0] hist;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got {w,v,b,d}=%b want %b", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_str(input string name, input string got, input string want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, got, want);
    end
  endtask

  task automatic cap_clear();
    wave = ""; busy_n = 0; done_n = 0; det_n = 0; vcnt = 0; hist = '0;
  endtask

  function automatic void model_step();
    if (!reset) begin
      exp_q.delete();
      m_cur = O_IDLE;
    end else begin
      if (m_cur[1] && abort) begin
        exp_q.delete();
      end else if (!m_cur[1] && start) begin
        for (int r = 0; r < int'(reps); r++) begin
          for (int k = 0; k < int'(PAT_W); k++) exp_q.push_back({PAT[PAT_W-1-k], 3'b110});
          if (r + 1 < int'(reps)) for (int g = 0; g < int'(gap); g++) exp_q.push_back(O_GAP);
        end
        exp_q.push_back(O_DONE);
      end
      m_cur = (exp_q.size() > 0) ? exp_q.pop_front() : O_IDLE;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", {w_out, valid, busy, done}, m_cur);
    if (busy) begin
      busy_n++;
      wave = {wave, valid ? (w_out ? "1" : "0") : "_"};
    end
    if (done) done_n++;
    if (valid) begin
      hist = {hist[2:0], w_out};
      vcnt++;
      if (vcnt >= 4 && hist == PAT) det_n++;
    end
  endtask

  task automatic run_until_done(input int limit);
    start = 1'b0;
    for (int i = 0; i < limit && done_n == 0; i++) tick();
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] rp;
    logic [3:0] gp;
    logic       ab;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 4'b1000};  // reset state
    tbl[1]  = '{1'b1, 1'b1, 8'd1, 4'd0, 1'b0, 4'b0110};  // reps=1: 0011
    tbl[2]  = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b0110};
    tbl[3]  = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1110};
    tbl[4]  = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1110};
    tbl[5]  = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1001};
    tbl[6]  = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1000};
    tbl[7]  = '{1'b1, 1'b1, 8'd0, 4'd0, 1'b0, 4'b1001};  // reps=0: done only
    tbl[8]  = '{1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 4'b1000};
    tbl[9]  = '{1'b1, 1'b1, 8'd2, 4'd1, 1'b0, 4'b0110};
    tbl[10] = '{1'b1, 1'b1, 8'd0, 4'd0, 1'b0, 4'b0110};  // start ignored while busy
    tbl[11] = '{1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 4'b1000};  // reset mid-shift, 3 cycles
    tbl[12] = '{1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 4'b1000};
    tbl[13] = '{1'b0, 1'b1, 8'd1, 4'd0, 1'b0, 4'b1000};
    tbl[14] = '{1'b1, 1'b0, 8'd0, 4'd0, 1'b1, 4'b1000};  // abort while idle
    tbl[15] = '{1'b1, 1'b1, 8'd1, 4'd0, 1'b1, 4'b0110};
    tbl[16] = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b0110};
    tbl[17] = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1110};
    tbl[18] = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1110};
    tbl[19] = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1001};
    tbl[20] = '{1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 4'b1000};

    for (int i = 0; i < 21; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; reps = tbl[i].rp;
      gap = tbl[i].gp; abort = tbl[i].ab;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {w_out, valid, busy, done}, tbl[i].exp);
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    exp_q.delete();
    m_cur = O_IDLE;

    // reps=3, gap=2
    cap_clear();
    reps = 8'd3; gap = 4'd2; start = 1'b1;
    tick();
    run_until_done(60);
    check_str("gap2_wave", wave, "0011__0011__0011");
    check_int("gap2_busy", busy_n, 16);
    check_int("gap2_done", done_n, 1);
    check_int("gap2_det", det_n, 3);
    tick();

    // reps=2, gap=0, start pulses and reps changes while busy
    cap_clear();
    reps = 8'd2; gap = 4'd0; start = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      start = (i % 2 == 0); reps = 8'd5; gap = 4'd3;
      tick();
    end
    run_until_done(20);
    check_str("b2b_wave", wave, "00110011");
    check_int("b2b_busy", busy_n, 8);
    check_int("b2b_det", det_n, 2);
    tick();

    // abort at 2nd bit of rep 2 of 4, then immediate restart
    cap_clear();
    reps = 8'd4; gap = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("abort_pre", {w_out, valid, busy, done}, 4'b0110);
    abort = 1'b1;
    tick();
    check("abort_idle", {w_out, valid, busy, done}, O_IDLE);
    abort = 1'b0; start = 1'b1; reps = 8'd1; gap = 4'd0;
    tick();
    check("abort_restart", {w_out, valid, busy, done}, 4'b0110);
    check_int("abort_no_done", done_n, 0);
    run_until_done(20);
    tick();

    // maximum repetition count
    cap_clear();
    reps = 8'd255; gap = 4'd0; start = 1'b1;
    tick();
    run_until_done(1100);
    check_int("max_reps_busy", busy_n, 1020);
    check_int("max_reps_det", det_n, 255);
    tick();

    // maximum gap
    cap_clear();
    reps = 8'd2; gap = 4'd15; start = 1'b1;
    tick();
    run_until_done(60);
    check_int("max_gap_busy", busy_n, 23);
    check_int("max_gap_done", done_n, 1);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 3) == 0);
      reps  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      gap   = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      abort = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
